gzip_out_stream_bridge: RTL and testbench

- Parametrised successor to the core's output-FIFO-to-AXIS adapter.
- Drains a fixed-read-latency FIFO (any latency 1..N) into an AXI4-Stream master through a credit-controlled skid buffer. The result is full throughput with no beat loss under arbitrary tready back-pressure.
- Adds per-beat byte-order swap, beat/packet counters and a packet-done interrupt pulse.
- Sits between gzip_top's output FIFO and the output async AXIS FIFO in the core_clock domain.

---
 rtl/gzip_out_stream_bridge.sv | 138 +++++++++++++
 tb/tb_gzip_out_stream_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_out_stream_bridge.sv
// Drains a fixed-read-latency FIFO into an AXI4-Stream master through a credit-guarded skid buffer, with byte swap, counters and irq.
// Latency: rden in cycle 0 -> tvalid in cycle RD_LATENCY+1. Backpressure: reads are only issued while buffered+in-flight < SKID_DEPTH.
// Optional stall counter port enabled by defining GZIP_OUT_BRIDGE_STALL_CNT_EN.
module gzip_out_stream_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  core_clock,
    input  logic                  bus_reset,
    input  logic                  rev_endianness_in,
    input  logic                  cnt_clr,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_last,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  pkt_done_irq,
    output logic                  busy
`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int PTR_W     = $clog2(SKID_DEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam int SUM_W     = OCC_W + 4;

    logic [RD_LATENCY-1:0] rd_sr;
    logic [SUM_W-1:0]      inflight_cnt;
    logic [SUM_W-1:0]      credit_sum;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  rst_hold;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] swapped_dat;
    logic [DATA_WIDTH-1:0] buf_dat [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] buf_last;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(rd_sr[i]);
        end
    end

    always_comb begin
        swapped_dat = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            swapped_dat[8*i +: 8] = fifo_data[8*(NUM_BYTES-1-i) +: 8];
        end
    end

    // Credit counts every read still in the pipe; a same-cycle pop is deliberately not credited.
    assign credit_sum    = SUM_W'(occ) + inflight_cnt;
    assign fifo_rden     = ~rst_hold & ~fifo_empty & (credit_sum < SUM_W'(SKID_DEPTH));
    assign push          = rd_sr[RD_LATENCY-1];
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = (occ != '0);
    assign m_axis_tdata  = m_axis_tvalid ? buf_dat[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid & buf_last[rd_ptr];
    assign busy          = (inflight_cnt != '0) | (occ != '0);

    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            rst_hold <= 1'b1;
            rd_sr    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            rst_hold <= 1'b0;
            rd_sr    <= (rd_sr << 1) | RD_LATENCY'(fifo_rden);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage needs no reset: every entry is written before occupancy exposes it.
    always_ff @(posedge core_clock) begin
        if (push) begin
            buf_dat[wr_ptr]  <= rev_endianness_in ? swapped_dat : fifo_data;
            buf_last[wr_ptr] <= fifo_last;
        end
    end

    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            beat_count   <= '0;
            pkt_count    <= '0;
            pkt_done_irq <= 1'b0;
        end else begin
            pkt_done_irq <= pop & m_axis_tlast;
            if (cnt_clr) begin
                beat_count <= '0;
                pkt_count  <= '0;
            end else if (pop) begin
                if (beat_count != '1) begin
                    beat_count <= beat_count + CNT_WIDTH'(1);
                end
                if (m_axis_tlast && (pkt_count != '1)) begin
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            stall_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end
`endif

    skid_no_overflow: assert property (@(posedge core_clock) disable iff (bus_reset)
        !(push && (occ == OCC_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_gzip_out_stream_bridge.sv
// Randomised bench: a latency-accurate source FIFO plus a queue-based reference of the stream, credit rule and counters.
module tb_gzip_out_stream_bridge;

    localparam int DW   = 32;
    localparam int RD   = 3;
    localparam int SD   = 8;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          core_clock = 1'b0;
    logic          bus_reset  = 1'b1;
    logic          rev_endianness_in = 1'b0;
    logic          cnt_clr    = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rden;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_last  = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] pkt_count;
    logic          pkt_done_irq;
    logic          busy;
`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
    logic [CW-1:0] stall_count;
`endif

    gzip_out_stream_bridge #(
        .DATA_WIDTH(DW), .RD_LATENCY(RD), .SKID_DEPTH(SD), .CNT_WIDTH(CW)
    ) dut (
        .core_clock       (core_clock),
        .bus_reset        (bus_reset),
        .rev_endianness_in(rev_endianness_in),
        .cnt_clr          (cnt_clr),
        .fifo_empty       (fifo_empty),
        .fifo_rden        (fifo_rden),
        .fifo_data        (fifo_data),
        .fifo_last        (fifo_last),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .beat_count       (beat_count),
        .pkt_count        (pkt_count),
        .pkt_done_irq     (pkt_done_irq),
        .busy             (busy)
`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    always #5 core_clock = ~core_clock;

    // Source FIFO contents, reads in flight, and beats owed to the stream (the buffer contents).
    logic [DW-1:0] src_d[$];
    logic          src_l[$];
    logic [DW-1:0] inf_d[$];
    logic          inf_l[$];
    int            inf_due[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int m_beat, m_pkt, m_stall;
    bit m_irq, hold_m;

    int rmode, revmode, clr_mode;
    int ph_beats, first_rden_cyc, first_vld_cyc, first_acc_cyc, last_acc_cyc, irq_cnt, rden_cnt;
    logic [DW-1:0] first_dat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] bswap(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW/8; i++) r[8*i +: 8] = x[DW-8-8*i +: 8];
        return r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic phase_start();
        ph_beats = 0; first_rden_cyc = -1; first_vld_cyc = -1;
        first_acc_cyc = -1; last_acc_cyc = -1; irq_cnt = 0; rden_cnt = 0;
    endtask

    task automatic load(input int n, input bit pattern, input bit rand_last);
        for (int k = 0; k < n; k++) begin
            src_d.push_back(pattern ? (32'h01020304 + k * 32'h04040404) : DW'($urandom));
            src_l.push_back((k == n - 1) || (rand_last && ($urandom_range(0, 5) == 0)));
        end
    endtask

    task automatic step_body();
        bit exp_vld, exp_rden, acc, lastflag, will_acc;
        case (rmode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
        rev_endianness_in = (revmode == 2) ? 1'($urandom_range(0, 1)) : (revmode == 1);
        will_acc = (exp_d.size() > 0) && m_axis_tready;
        cnt_clr = 1'b0;
        if (clr_mode == 1 && will_acc && ph_beats == 9) begin
            cnt_clr = 1'b1;
            clr_mode = 0;
        end else if (clr_mode == 2) begin
            cnt_clr = ($urandom_range(0, 39) == 0);
        end
        fifo_empty = (src_d.size() == 0);
        if (inf_d.size() > 0 && inf_due[0] == cyc) begin
            fifo_data = inf_d[0];
            fifo_last = inf_l[0];
        end else begin
            fifo_data = DW'($urandom);
            fifo_last = 1'($urandom_range(0, 1));
        end
        @(negedge core_clock);

        exp_vld  = (exp_d.size() > 0);
        exp_rden = !hold_m && (src_d.size() > 0) && (exp_d.size() + inf_d.size() < SD);
        chk("fifo_rden", fifo_rden, exp_rden);
        chk("tvalid", m_axis_tvalid, exp_vld);
        if (exp_vld) begin
            chk("tdata", m_axis_tdata, exp_d[0]);
            chk("tlast", m_axis_tlast, exp_l[0]);
        end
        chk("busy", busy, (exp_d.size() + inf_d.size()) != 0);
        chk("beat_count", beat_count, m_beat);
        chk("pkt_count", pkt_count, m_pkt);
        chk("pkt_done_irq", pkt_done_irq, m_irq);
`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
        chk("stall_count", stall_count, m_stall);
`endif

        if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (pkt_done_irq) irq_cnt++;
        acc = exp_vld && m_axis_tready;
        lastflag = 1'b0;
        if (acc) begin
            if (ph_beats == 0) begin
                first_acc_cyc = cyc;
                first_dat = exp_d[0];
            end
            last_acc_cyc = cyc;
            ph_beats++;
            lastflag = exp_l[0];
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
        end
        m_stall = cnt_clr ? 0 : ((exp_vld && !m_axis_tready) ? sat_inc(m_stall) : m_stall);
        m_beat  = cnt_clr ? 0 : (acc ? sat_inc(m_beat) : m_beat);
        m_pkt   = cnt_clr ? 0 : ((acc && lastflag) ? sat_inc(m_pkt) : m_pkt);
        m_irq   = acc && lastflag;
        if (inf_d.size() > 0 && inf_due[0] == cyc) begin
            exp_d.push_back(rev_endianness_in ? bswap(inf_d[0]) : inf_d[0]);
            exp_l.push_back(inf_l[0]);
            void'(inf_d.pop_front());
            void'(inf_l.pop_front());
            void'(inf_due.pop_front());
        end
        if (fifo_rden) begin
            rden_cnt++;
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
            if (src_d.size() > 0) begin
                inf_d.push_back(src_d.pop_front());
                inf_l.push_back(src_l.pop_front());
                inf_due.push_back(cyc + RD);
            end
        end
        hold_m = 1'b0;
        cyc++;
    endtask

    task automatic cycle();
        @(posedge core_clock);
        #1;
        step_body();
    endtask

    task automatic run_idle(input string nm, input int budget);
        int n = 0;
        while ((src_d.size() + inf_d.size() + exp_d.size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, (src_d.size() + inf_d.size() + exp_d.size()) == 0, 1'b1);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        #2 bus_reset = 1'b1;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rden", fifo_rden, 1'b0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_beat", beat_count, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_irq", pkt_done_irq, 1'b0);
`ifdef GZIP_OUT_BRIDGE_STALL_CNT_EN
        chk("rst_stall", stall_count, 0);
`endif
        src_d.delete(); src_l.delete(); inf_d.delete(); inf_l.delete(); inf_due.delete();
        exp_d.delete(); exp_l.delete();
        m_beat = 0; m_pkt = 0; m_stall = 0; m_irq = 1'b0;
        repeat (2) @(posedge core_clock);
        #1 bus_reset = 1'b0;
        hold_m = 1'b1;
        step_body();
    endtask

    initial begin
        int n;
        rmode = 0; revmode = 0; clr_mode = 0;
        phase_start();
        do_reset();

        // Plain packet of 8 known words.
        phase_start(); rmode = 0; revmode = 0; load(8, 1'b1, 1'b0);
        run_idle("p1_drain", 200);
        chk("p1_latency", first_vld_cyc - first_rden_cyc, RD + 1);
        chk("p1_first_dat", first_dat, 32'h01020304);
        chk("p1_gapless", last_acc_cyc - first_acc_cyc, 7);
        chk("p1_beats", ph_beats, 8);
        chk("p1_beat_count", beat_count, 8);
        chk("p1_pkt_count", pkt_count, 1);
        chk("p1_irq_pulses", irq_cnt, 1);

        // Same packet byte-reversed.
        phase_start(); revmode = 1; load(8, 1'b1, 1'b0);
        run_idle("p2_drain", 200);
        chk("p2_first_dat", first_dat, 32'h04030201);
        chk("p2_beat_count", beat_count, 16);
        chk("p2_pkt_count", pkt_count, 2);

        // Sink stalled with 10 words available: exactly SD reads, then a gapless drain.
        phase_start(); revmode = 0; rmode = 3; load(10, 1'b0, 1'b0);
        repeat (20) cycle();
        chk("p3_stall_reads", rden_cnt, SD);
        rmode = 0;
        run_idle("p3_drain", 200);
        chk("p3_gapless", last_acc_cyc - first_acc_cyc, 9);
        chk("p3_beat_count", beat_count, 26);

        // Toggling ready over 32 words, counters cleared on the 10th accept.
        phase_start(); rmode = 1; clr_mode = 1; load(32, 1'b0, 1'b0);
        run_idle("p4_drain", 400);
        chk("p4_beats", ph_beats, 32);
        chk("p4_beat_count", beat_count, 22);
        chk("p4_pkt_count", pkt_count, 1);

        // Random ready/endianness, enough beats to saturate.
        phase_start(); rmode = 2; revmode = 2; clr_mode = 0; load(40, 1'b0, 1'b1);
        run_idle("p5_drain", 800);
        chk("p5_beat_sat", beat_count, CMAX);

        phase_start(); clr_mode = 2; load(60, 1'b0, 1'b1);
        run_idle("p6_drain", 1200);

        // Reset with reads in flight and beats buffered.
        phase_start(); rmode = 3; revmode = 0; clr_mode = 0; load(20, 1'b0, 1'b0);
        n = 0;
        while (!(exp_d.size() == 3 && inf_d.size() >= 2) && n < 50) begin
            cycle();
            n++;
        end
        chk("p7_prereset_state", (exp_d.size() == 3 && inf_d.size() >= 2), 1'b1);
        do_reset();
        phase_start(); rmode = 0; load(4, 1'b1, 1'b0);
        run_idle("p7_drain", 200);
        chk("p7_first_dat", first_dat, 32'h01020304);
        chk("p7_beat_count", beat_count, 4);
        chk("p7_pkt_count", pkt_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
